// File: rtl/shift_reg_sched.sv
// shift_reg_sched: round-robin two-requester scheduler that serially loads an external shift register
// and returns the captured parallel word over a valid/ready response channel.
module shift_reg_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_a,
  input  logic [WIDTH-1:0] req_data_a,
  input  logic             req_dir_a,
  output logic             req_ready_a,
  input  logic             req_valid_b,
  input  logic [WIDTH-1:0] req_data_b,
  input  logic             req_dir_b,
  output logic             req_ready_b,
  output logic             sr_shift_left,
  output logic             sr_shift_right,
  output logic             sr_serial_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CAPT, RESP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] word;
  logic dir, last_b, grant_a, grant_b, accept;
  // A wins unless B is alone or A was granted last
  assign grant_a = req_valid_a && (!req_valid_b || last_b);
  assign grant_b = req_valid_b && !grant_a;
  assign accept = rst && state == IDLE && (req_valid_a || req_valid_b);
  assign req_ready_a = accept && grant_a;
  assign req_ready_b = accept && grant_b;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE  ? (accept ? SHIFT : IDLE) :
                state == SHIFT ? (cnt == LAST ? CAPT : SHIFT) :
                state == CAPT  ? RESP :
                                 (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      word      <= '0;
      dir       <= 1'b0;
      last_b    <= 1'b1;
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (accept) begin
        word   <= grant_a ? req_data_a : req_data_b;
        dir    <= grant_a ? req_dir_a : req_dir_b;
        rsp_id <= grant_b;
        last_b <= grant_b;
        cnt    <= '0;
      end
      if (state == SHIFT && cnt != LAST) cnt <= cnt + 1'b1;
      if (state == CAPT) begin
        rsp_data  <= sr_q;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
  // Left shifts feed the MSB first, right shifts the LSB first, so both end with sr_q == word
  always_comb begin
    sr_shift_left  = state == SHIFT && !dir;
    sr_shift_right = state == SHIFT && dir;
    sr_serial_in   = state == SHIFT && (dir ? word[cnt] : word[LAST - cnt]);
    busy           = state != IDLE;
  end
endmodule

// File: tb/tb_shift_reg_sched.sv
// tb_shift_reg_sched: directed bench with a behavioural 4-bit shift register attached to the scheduler.
module tb_shift_reg_sched;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid_a = 1'b0, req_dir_a = 1'b0, req_valid_b = 1'b0, req_dir_b = 1'b0;
  logic [W-1:0] req_data_a = '0, req_data_b = '0;
  logic req_ready_a, req_ready_b, sr_shift_left, sr_shift_right, sr_serial_in;
  logic rsp_valid, rsp_id, busy, rsp_ready = 1'b1;
  logic [W-1:0] rsp_data, sr_q;
  logic [W-1:0] sr_reg = '0;
  int n_tests = 0, n_fail = 0;

  shift_reg_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_a(req_valid_a), .req_data_a(req_data_a), .req_dir_a(req_dir_a), .req_ready_a(req_ready_a),
    .req_valid_b(req_valid_b), .req_data_b(req_data_b), .req_dir_b(req_dir_b), .req_ready_b(req_ready_b),
    .sr_shift_left(sr_shift_left), .sr_shift_right(sr_shift_right), .sr_serial_in(sr_serial_in),
    .sr_q(sr_q), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  assign sr_q = sr_reg;
  always @(posedge clk) begin
    if (sr_shift_left) sr_reg <= {sr_reg[W-2:0], sr_serial_in};
    else if (sr_shift_right) sr_reg <= {sr_serial_in, sr_reg[W-1:1]};
  end

  always @(negedge clk) begin
    #2;
    n_tests++;
    if ((sr_shift_left && sr_shift_right) || (busy && (req_ready_a || req_ready_b)) || (req_ready_a && req_ready_b)) begin
      n_fail++;
      $display("FAIL concurrency: sl=%b sr=%b busy=%b ready_a=%b ready_b=%b, required no overlapping controls/readies",
               sr_shift_left, sr_shift_right, busy, req_ready_a, req_ready_b);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic run_txn(input string name, input logic id, input logic [W-1:0] d, input logic dr);
    logic [W-1:0] seen;
    req_valid_a = !id; req_valid_b = id;
    req_data_a = d; req_data_b = d; req_dir_a = dr; req_dir_b = dr;
    #1;
    n_tests++;
    if ({req_ready_a, req_ready_b} !== {!id, id}) begin
      n_fail++;
      $display("FAIL %s ready: got a=%b b=%b, required a=%b b=%b", name, req_ready_a, req_ready_b, !id, id);
    end
    @(negedge clk);
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    for (int k = 0; k < W; k++) begin
      #1;
      seen[k] = dr ? d[k] : d[W-1-k];
      n_tests++;
      if ({sr_shift_left, sr_shift_right, sr_serial_in, busy, rsp_valid} !== {!dr, dr, seen[k], 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL %s shift k=%0d: got sl=%b sr=%b si=%b busy=%b rv=%b, required sl=%b sr=%b si=%b busy=1 rv=0",
                 name, k, sr_shift_left, sr_shift_right, sr_serial_in, busy, rsp_valid, !dr, dr, seen[k]);
      end
      @(negedge clk);
    end
    #1;
    n_tests++;
    if ({sr_shift_left, sr_shift_right, sr_serial_in, busy, rsp_valid} !== 5'b00010) begin
      n_fail++;
      $display("FAIL %s capt: got sl=%b sr=%b si=%b busy=%b rv=%b, required 0 0 0 1 0",
               name, sr_shift_left, sr_shift_right, sr_serial_in, busy, rsp_valid);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, d, id}) begin
      n_fail++;
      $display("FAIL %s rsp: got valid=%b data=%b id=%b, required valid=1 data=%b id=%b",
               name, rsp_valid, rsp_data, rsp_id, d, id);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; req_valid_a = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if ({req_ready_a, req_ready_b, sr_shift_left, sr_shift_right, sr_serial_in, rsp_valid, rsp_id, busy, rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b%b sl=%b sr=%b si=%b rv=%b id=%b busy=%b data=%b, required all 0",
               req_ready_a, req_ready_b, sr_shift_left, sr_shift_right, sr_serial_in, rsp_valid, rsp_id, busy, rsp_data);
    end
    req_valid_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_a;
    run_txn("single_a", 1'b0, 4'b1011, 1'b0);
  endtask

  task automatic test_single_b;
    run_txn("single_b", 1'b1, 4'b0110, 1'b1);
  endtask

  task automatic test_back_to_back;
    int gc[4];
    logic gid[4];
    int n_g = 0, n_r = 0;
    req_data_a = 4'b1100; req_dir_a = 1'b0;
    req_data_b = 4'b0011; req_dir_b = 1'b1;
    req_valid_a = 1'b1; req_valid_b = 1'b1;
    for (int c = 0; c < 60 && n_r < 4; c++) begin
      #1;
      if ((req_ready_a || req_ready_b) && n_g < 4) begin
        gc[n_g] = c; gid[n_g] = req_ready_b; n_g++;
      end
      if (rsp_valid) begin
        n_tests++;
        if ({rsp_data, rsp_id} !== {(n_r % 2 == 1) ? 4'b0011 : 4'b1100, n_r % 2 == 1}) begin
          n_fail++;
          $display("FAIL b2b rsp %0d: got data=%b id=%b, required data=%b id=%b",
                   n_r, rsp_data, rsp_id, (n_r % 2 == 1) ? 4'b0011 : 4'b1100, n_r % 2 == 1);
        end
        n_r++;
      end
      @(negedge clk);
      if (n_g == 4) begin
        req_valid_a = 1'b0; req_valid_b = 1'b0;
      end
    end
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    n_tests++;
    if (n_g != 4 || n_r != 4) begin
      n_fail++;
      $display("FAIL b2b count: got grants=%0d rsps=%0d, required 4 and 4", n_g, n_r);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (gid[i] !== (i % 2 == 1) || (i > 0 && gc[i] - gc[i-1] != 7)) begin
          n_fail++;
          $display("FAIL b2b grant %0d: got id=%b gap=%0d, required id=%b gap=7",
                   i, gid[i], i > 0 ? gc[i] - gc[i-1] : 7, i % 2 == 1);
        end
      end
    end
  endtask

  task automatic test_hold;
    rsp_ready = 1'b0;
    req_valid_a = 1'b1; req_data_a = 4'b1001; req_dir_a = 1'b0;
    @(negedge clk);
    req_valid_a = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold wait: got rsp_valid=%b, required 1 within 20 cycles", rsp_valid);
    end
    req_valid_a = 1'b1; req_valid_b = 1'b1; req_data_b = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests++;
      if ({rsp_valid, rsp_data, rsp_id, busy, req_ready_a, req_ready_b} !== {1'b1, 4'b1001, 1'b0, 1'b1, 2'b00}) begin
        n_fail++;
        $display("FAIL hold cycle %0d: got rv=%b data=%b id=%b busy=%b rdy=%b%b, required 1 1001 0 1 00",
                 i, rsp_valid, rsp_data, rsp_id, busy, req_ready_a, req_ready_b);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if ({busy, rsp_valid, req_ready_a, req_ready_b} !== 4'b0001) begin
      n_fail++;
      $display("FAIL hold release: got busy=%b rv=%b rdy=%b%b, required busy=0 rv=0 rdy=01",
               busy, rsp_valid, req_ready_a, req_ready_b);
    end
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    req_valid_a = 1'b1; req_data_a = 4'b0101; req_dir_a = 1'b0;
    @(negedge clk);
    req_valid_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if ({busy, sr_shift_left, sr_serial_in} !== 3'b110) begin
      n_fail++;
      $display("FAIL rst_mid pre: got busy=%b sl=%b si=%b, required 1 1 0", busy, sr_shift_left, sr_serial_in);
    end
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({req_ready_a, req_ready_b, sr_shift_left, sr_shift_right, sr_serial_in, rsp_valid, rsp_id, busy, rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid async: got rdy=%b%b sl=%b sr=%b si=%b rv=%b id=%b busy=%b data=%b, required all 0",
               req_ready_a, req_ready_b, sr_shift_left, sr_shift_right, sr_serial_in, rsp_valid, rsp_id, busy, rsp_data);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rsp_valid || busy) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rst_mid quiet: got %0d cycles with rsp_valid/busy, required 0", bad);
    end
    run_txn("after_rst", 1'b0, 4'b1110, 1'b1);
  endtask

  initial begin
    test_reset;
    test_single_a;
    test_single_b;
    test_back_to_back;
    test_hold;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_reg_sched.md
# shift_reg_sched

Two-requester scheduler for the 4-bit serial shift register datapath. It arbitrates round-robin between requesters A and B, each offering a parallel word and a shift direction. It serially loads the granted word into the external shift register by driving its shift_left/shift_right/serial_in controls for WIDTH cycles. It then captures the register's parallel output and returns it to the winning requester over a valid/ready response channel.

## Interface
- WIDTH, 4, shift register length in bits; also the width of the request and response words (≥2)
- clk  in  1  rising-edge clock shared with the shift register
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid_a / req_valid_b  in  1  request pending from A / B
- req_data_a / req_data_b  in  WIDTH  word to load
- req_dir_a / req_dir_b  in  1  0 = load via left shift, 1 = load via right shift
- req_ready_a / req_ready_b  out  1  accept strobe; request transfers when valid && ready
- sr_shift_left  out  1  drives shift register shift_left
- sr_shift_right  out  1  drives shift register shift_right
- sr_serial_in  out  1  drives shift register serial_in
- sr_q  in  WIDTH  shift register parallel data_out
- rsp_valid  out  1  response word available
- rsp_data  out  WIDTH  captured shift register contents
- rsp_id  out  1  0 = response belongs to A, 1 = to B
- rsp_ready  in  1  response consumer accepts
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, SHIFT, CAPT, RESP.
- IDLE:
  - Arbitration is combinational.
  - If exactly one requester is valid, that requester wins.
  - If both are valid, the requester not granted last wins. The last-grant pointer resets to B, so A wins the first contest.
  - req_ready of the winner is 1; all other ready outputs are 0.
  - On the accept edge: latch word, dir and id; set the counter to 0; update the last-grant pointer; go to SHIFT.
- SHIFT:
  - Exactly one of sr_shift_left (dir=0) or sr_shift_right (dir=1) is high.
  - At count k, sr_serial_in is word[WIDTH-1-k] for left shifts and word[k] for right shifts. Both orders leave sr_q == word after WIDTH shifts.
  - The counter increments every cycle. After the cycle with k = WIDTH-1, go to CAPT.
- CAPT:
  - Both shift controls are 0.
  - On the clock edge, rsp_data <= sr_q and rsp_valid <= 1; rsp_id is already valid. Go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready = 1.
  - On that edge, rsp_valid <= 0 and the state returns to IDLE.
- Outside SHIFT, sr_shift_left, sr_shift_right and sr_serial_in are 0. sr_shift_left and sr_shift_right are never high together.
- Both req_ready outputs are 0 outside IDLE. Requests arriving while busy wait; requesters hold valid and data stable until accepted.
- The counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE, counter 0, last-grant pointer B.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - All sr_* outputs 0; req_ready_a and req_ready_b = 0 while in reset.
- Reset mid-operation aborts the transaction immediately: shift controls drop asynchronously and no response is issued. Shift register contents are not restored.
- Latency, with the accept edge at cycle 0:
  - SHIFT occupies cycles 1..WIDTH.
  - CAPT occupies cycle WIDTH+1.
  - rsp_valid is first high in cycle WIDTH+2.
- Minimum request-to-request period is WIDTH+3 cycles (rsp_ready held high). The next accept can occur in the cycle after the response handshake.
- req_ready may depend combinationally on req_valid_a/b and state. All other outputs are registered or decoded from state and the counter only.
- No combinational path exists from rsp_ready to any output.

## Test plan
- Single A request, WIDTH=4, data 4'b1011, dir=0:
  - sr_serial_in sequence is 1,0,1,1 with sr_shift_left high for 4 cycles.
  - rsp_valid rises in cycle 6 with rsp_data=4'b1011, rsp_id=0.
- Single B request, data 4'b0110, dir=1:
  - sr_serial_in is 0,1,1,0 with sr_shift_right high for 4 cycles.
  - rsp_data=4'b0110, rsp_id=1.
- A and B both held valid for 4 transactions with rsp_ready=1: grants are A,B,A,B, each spaced 7 cycles apart.
- rsp_ready held 0 for 10 cycles in RESP:
  - rsp_valid and rsp_data stay constant; busy=1.
  - Both readies stay 0 despite pending requests.
- rst pulled low in SHIFT at count 2:
  - All outputs go to reset values within the same cycle; no rsp_valid follows.
  - After release, a new A request completes normally.
- Concurrency checks on all traffic: sr_shift_left && sr_shift_right never both 1, and no ready is issued when state ≠ IDLE.
